// File: rtl/nibble_rsp_deser.sv
// Purpose : collect NibbleW-bit response nibbles into WordW-bit words and route
//           each word to the inst or data port by an in-order tag FIFO.
// Latency : word valid one cycle after its last nibble is accepted; NumNib+1
//           cycles minimum per word.
// Backpr. : rsp_ready_o low while no tag is outstanding or a word is being
//           delivered; a data word is held until data_pready_i.
// Ports   : clk/rst_n (async, active-low); tag_* push side of the tag FIFO with
//           full/empty/sticky overflow; rsp_* nibble input (valid/ready);
//           inst_rsp_* one-cycle strobe; data_p* valid/ready load response.
module nibble_rsp_deser #(
  parameter int NibbleW  = 4,
  parameter int WordW    = 32,
  parameter int TagDepth = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tag_push_i,
  input  logic               tag_is_inst_i,
  output logic               tag_full_o,
  output logic               tag_empty_o,
  output logic               overflow_o,
  input  logic [NibbleW-1:0] rsp_nibble_i,
  input  logic               rsp_valid_i,
  output logic               rsp_ready_o,
  output logic [WordW-1:0]   inst_rsp_data_o,
  output logic               inst_rsp_valid_o,
  output logic [WordW-1:0]   data_pdata_o,
  output logic               data_pvalid_o,
  input  logic               data_pready_i
);

  localparam int NumNib = WordW / NibbleW;
  localparam int CntW   = (NumNib > 1) ? $clog2(NumNib) : 1;
  localparam int PtrW   = (TagDepth > 1) ? $clog2(TagDepth) : 1;
  localparam int OccW   = $clog2(TagDepth + 1);

  typedef enum logic {COLLECT, DELIVER} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [TagDepth-1:0] tag_mem_q, tag_mem_d;
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic [OccW-1:0]     occ_q, occ_d;
  logic                ovf_q, ovf_d;
  logic                inst_vld_q, inst_vld_d;
  logic                data_vld_q, data_vld_d;

  logic full, empty, head_is_inst, accept, pop, push_ok;

  assign full         = (occ_q == OccW'(TagDepth));
  assign empty        = (occ_q == '0);
  assign head_is_inst = tag_mem_q[rptr_q];

  assign rsp_ready_o      = (state_q == COLLECT) && !empty;
  assign tag_full_o       = full;
  assign tag_empty_o      = empty;
  assign overflow_o       = ovf_q;
  assign inst_rsp_data_o  = word_q;
  assign data_pdata_o     = word_q;
  assign inst_rsp_valid_o = inst_vld_q;
  assign data_pvalid_o    = data_vld_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    inst_vld_d = inst_vld_q;
    data_vld_d = data_vld_q;
    tag_mem_d  = tag_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    ovf_d      = ovf_q;

    accept = rsp_ready_o && rsp_valid_i;
    // The registered valids already encode the head tag while in DELIVER.
    pop    = (state_q == DELIVER) && (inst_vld_q || (data_vld_q && data_pready_i));
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    push_ok = tag_push_i && (!full || pop);

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          // Shift in from the top: first nibble lands in the lowest slot.
          word_d = {rsp_nibble_i, word_q[WordW-1:NibbleW]};
          if (cnt_q == CntW'(NumNib - 1)) begin
            cnt_d      = '0;
            state_d    = DELIVER;
            inst_vld_d = head_is_inst;
            data_vld_d = !head_is_inst;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DELIVER: begin
        if (pop) begin
          state_d    = COLLECT;
          inst_vld_d = 1'b0;
          data_vld_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (pop) begin
      rptr_d = (rptr_q == PtrW'(TagDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push_ok) begin
      tag_mem_d[wptr_q] = tag_is_inst_i;
      wptr_d = (wptr_q == PtrW'(TagDepth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (tag_push_i && !push_ok) begin
      ovf_d = 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      word_q     <= '0;
      tag_mem_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      ovf_q      <= 1'b0;
      inst_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      tag_mem_q  <= tag_mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      ovf_q      <= ovf_d;
      inst_vld_q <= inst_vld_d;
      data_vld_q <= data_vld_d;
    end
  end

endmodule

// File: tb/tb_nibble_rsp_deser.sv
module tb_nibble_rsp_deser;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tag_push_i, tag_is_inst_i;
  logic        tag_full_o, tag_empty_o, overflow_o;
  logic [3:0]  rsp_nibble_i;
  logic        rsp_valid_i, rsp_ready_o;
  logic [31:0] inst_rsp_data_o, data_pdata_o;
  logic        inst_rsp_valid_o, data_pvalid_o, data_pready_i;

  int checks = 0;
  int errors = 0;

  nibble_rsp_deser #(.NibbleW(4), .WordW(32), .TagDepth(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tag_push_i       (tag_push_i),
    .tag_is_inst_i    (tag_is_inst_i),
    .tag_full_o       (tag_full_o),
    .tag_empty_o      (tag_empty_o),
    .overflow_o       (overflow_o),
    .rsp_nibble_i     (rsp_nibble_i),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_ready_o      (rsp_ready_o),
    .inst_rsp_data_o  (inst_rsp_data_o),
    .inst_rsp_valid_o (inst_rsp_valid_o),
    .data_pdata_o     (data_pdata_o),
    .data_pvalid_o    (data_pvalid_o),
    .data_pready_i    (data_pready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding tags as a queue, received nibbles as a list; the word value is
  // the positional sum of the nibbles. "m_deliv" means a finished word waits.
  int          m_tags[$];
  int          m_nibs[$];
  bit          m_deliv;
  logic [31:0] m_word;
  bit          m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tags.delete();
      m_nibs.delete();
      m_deliv = 0;
      m_word  = '0;
      m_ovf   = 0;
    end else begin
      int  sz;
      bit  ready, pop;
      sz    = m_tags.size();
      ready = !m_deliv && sz > 0;
      pop   = m_deliv && (m_tags[0] == 1 || data_pready_i);
      if (pop) begin
        void'(m_tags.pop_front());
        m_deliv = 0;
      end
      if (ready && rsp_valid_i) begin
        m_nibs.push_back(int'(rsp_nibble_i));
        if (m_nibs.size() == 8) begin
          m_word = '0;
          for (int i = 0; i < 8; i++) m_word = m_word + (32'(m_nibs[i]) << (4 * i));
          m_nibs.delete();
          m_deliv = 1;
        end
      end
      if (tag_push_i) begin
        if (sz < DEPTH || pop) m_tags.push_back(tag_is_inst_i ? 1 : 0);
        else m_ovf = 1;
      end
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [31:0] last_inst, last_data;
  int          inst_cnt = 0, data_cnt = 0;

  always @(negedge clk) begin
    bit e_inst, e_data;
    e_inst = m_deliv && m_tags.size() > 0 && m_tags[0] == 1;
    e_data = m_deliv && m_tags.size() > 0 && m_tags[0] == 0;
    chk("rsp_ready", 32'(rsp_ready_o), 32'(!m_deliv && m_tags.size() > 0));
    chk("tag_empty", 32'(tag_empty_o), 32'(m_tags.size() == 0));
    chk("tag_full",  32'(tag_full_o),  32'(m_tags.size() == DEPTH));
    chk("overflow",  32'(overflow_o),  32'(m_ovf));
    chk("inst_vld",  32'(inst_rsp_valid_o), 32'(e_inst));
    chk("data_vld",  32'(data_pvalid_o),    32'(e_data));
    if (e_inst) chk("inst_data", inst_rsp_data_o, m_word);
    if (e_data) chk("data_data", data_pdata_o, m_word);
    if (!rst_n) begin
      chk("rst_inst_data", inst_rsp_data_o, 32'h0);
      chk("rst_data_data", data_pdata_o, 32'h0);
    end
    if (inst_rsp_valid_o) begin last_inst = inst_rsp_data_o; inst_cnt++; end
    if (data_pvalid_o && data_pready_i) begin last_data = data_pdata_o; data_cnt++; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit inst);
    tag_push_i    = 1'b1;
    tag_is_inst_i = inst;
    cyc();
    tag_push_i    = 1'b0;
  endtask

  // Sends nibbles [from, upto) of w, each waiting (bounded) for rsp_ready_o.
  task automatic send_word(input logic [31:0] w, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      int n;
      n = 0;
      rsp_nibble_i = w[4*i +: 4];
      rsp_valid_i  = 1'b1;
      while (!rsp_ready_o && n < 50) begin cyc(); n++; end
      if (n == 50) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=0 expected=1 nibble=%0d", i);
      end
      cyc();
    end
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic;
    rst_n = 1'b0;
    tag_push_i = 0; tag_is_inst_i = 0;
    rsp_nibble_i = 0; rsp_valid_i = 0; data_pready_i = 0;
    cyc(); cyc();
    chk("reset_ready", 32'(rsp_ready_o), 32'h0);
    chk("reset_empty", 32'(tag_empty_o), 32'h1);
    rst_n = 1'b1;
    cyc();

    // 1: instruction word 0x87654321, one-cycle strobe after last accept
    push(1);
    ic = inst_cnt;
    send_word(32'h87654321, 0, 8);
    chk("s1_strobe_on", 32'(inst_rsp_valid_o), 32'h1);
    chk("s1_word", inst_rsp_data_o, 32'h87654321);
    cyc();
    chk("s1_strobe_off", 32'(inst_rsp_valid_o), 32'h0);
    chk("s1_strobe_cnt", 32'(inst_cnt - ic), 32'h1);
    chk("s1_empty", 32'(tag_empty_o), 32'h1);

    // 2: data word held under backpressure
    push(0);
    send_word(32'h10FEDCBA, 0, 8);
    for (int k = 0; k < 5; k++) begin
      chk("s2_hold_vld", 32'(data_pvalid_o), 32'h1);
      chk("s2_hold_dat", data_pdata_o, 32'h10FEDCBA);
      cyc();
    end
    data_pready_i = 1'b1;
    cyc();
    data_pready_i = 1'b0;
    chk("s2_cleared", 32'(data_pvalid_o), 32'h0);
    chk("s2_captured", last_data, 32'h10FEDCBA);

    // 3: nibble stalls with no tag, accepted right after a push
    rsp_nibble_i = 4'h5;
    rsp_valid_i  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("s3_stall", 32'(rsp_ready_o), 32'h0);
      cyc();
    end
    push(1);
    chk("s3_ready_next", 32'(rsp_ready_o), 32'h1);
    cyc();
    send_word(32'h76543215, 1, 8);
    cyc();
    chk("s3_word", last_inst, 32'h76543215);

    // 4: inst then data tags, two words in order
    push(1);
    push(0);
    chk("s4_full", 32'(tag_full_o), 32'h1);
    data_pready_i = 1'b1;
    send_word(32'h11111111, 0, 8);
    cyc();
    chk("s4_inst", last_inst, 32'h11111111);
    send_word(32'h22222222, 0, 8);
    cyc();
    chk("s4_data", last_data, 32'h22222222);
    data_pready_i = 1'b0;

    // 5: overflow when full, then push coincident with a pop is kept
    push(1);
    push(0);
    push(1);
    chk("s5_ovf", 32'(overflow_o), 32'h1);
    chk("s5_full", 32'(tag_full_o), 32'h1);
    send_word(32'h33333333, 0, 8);
    push(0);
    chk("s5_full_after_pop", 32'(tag_full_o), 32'h1);
    chk("s5_ovf_kept", 32'(overflow_o), 32'h1);
    chk("s5_inst", last_inst, 32'h33333333);
    data_pready_i = 1'b1;
    send_word(32'h44444444, 0, 8);
    send_word(32'h55555555, 0, 8);
    cyc();
    data_pready_i = 1'b0;
    chk("s5_data", last_data, 32'h55555555);
    chk("s5_empty", 32'(tag_empty_o), 32'h1);

    // 6: reset mid-word discards everything
    push(1);
    send_word(32'hDEADBEEF, 0, 3);
    rst_n = 1'b0;
    #1;
    chk("s6_ready", 32'(rsp_ready_o), 32'h0);
    chk("s6_empty", 32'(tag_empty_o), 32'h1);
    chk("s6_ovf", 32'(overflow_o), 32'h0);
    chk("s6_data", inst_rsp_data_o, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    push(1);
    send_word(32'hCAFEF00D, 0, 8);
    chk("s6_word", inst_rsp_data_o, 32'hCAFEF00D);
    cyc();
    chk("s6_captured", last_inst, 32'hCAFEF00D);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_rsp_deser.md
# nibble_rsp_deser

Response-path deserializer for the off-chip nibble memory link of the Snitch tile. It collects 4-bit response nibbles from the pad inputs and assembles them into 32-bit words. Each word goes either to the core's instruction port or to its data response port, according to an in-order tag FIFO of outstanding read requests. It sits directly downstream of the request serializer: the serializer pushes one tag per accepted read, and this block consumes the matching response.

## Interface

- `NibbleW`, 4: response nibble width in bits.
- `WordW`, 32: assembled word width; must be a multiple of `NibbleW`. `NumNib = WordW/NibbleW` (8 with the defaults).
- `TagDepth`, 2: maximum number of outstanding reads; must be ≥ 1.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tag_push_i`  in  1  a read request was accepted on the link this cycle.
- `tag_is_inst_i`  in  1  owner of the pushed request: 1 = instruction fetch, 0 = data load.
- `tag_full_o`  out  1  tag FIFO holds `TagDepth` entries.
- `tag_empty_o`  out  1  tag FIFO holds no entries.
- `overflow_o`  out  1  sticky flag: a push was dropped.
- `rsp_nibble_i`  in  `NibbleW`  response nibble from the pads.
- `rsp_valid_i`  in  1  response nibble valid.
- `rsp_ready_o`  out  1  block accepts a nibble this cycle.
- `inst_rsp_data_o`  out  `WordW`  instruction word.
- `inst_rsp_valid_o`  out  1  one-cycle strobe; the core always accepts it.
- `data_pdata_o`  out  `WordW`  load data.
- `data_pvalid_o`  out  1  load response valid.
- `data_pready_i`  in  1  core accepts the load response.

## Operation

- **Tag FIFO.** Circular buffer with `TagDepth` entries of 1 bit each, holding read tags in request order.
  - Push when `tag_push_i` is high and (not full, or a pop occurs in the same cycle).
  - A push while full with no pop in that cycle is dropped and sets `overflow_o`. `overflow_o` clears only on reset.
  - Pointers wrap modulo `TagDepth`.
- **FSM states:** COLLECT and DELIVER.
- **COLLECT.**
  - `rsp_ready_o = !tag_empty_o`. A nibble arriving while no tag is outstanding stalls; it is never dropped.
  - Accept a nibble on `rsp_valid_i && rsp_ready_o`: `word <= {rsp_nibble_i, word[WordW-1:NibbleW]}`, `cnt <= cnt+1`. The first nibble received ends up in `word[NibbleW-1:0]`.
  - On the accept with `cnt == NumNib-1`: `cnt <= 0`, go to DELIVER.
- **DELIVER.** `rsp_ready_o = 0`. The head tag selects the destination.
  - Instruction tag: `inst_rsp_valid_o = 1` for exactly one cycle, pop the tag, return to COLLECT.
  - Data tag: `data_pvalid_o = 1`, with `data_pdata_o` held stable until `data_pready_i`. In the cycle `data_pready_i` is high, pop the tag and return to COLLECT.
  - `data_pready_i` low: stay in DELIVER indefinitely.
- **Output data.** `inst_rsp_data_o` and `data_pdata_o` both drive the word register and change only while in COLLECT. Consumers qualify them with their valid.
- **Valids are mutually exclusive.** `inst_rsp_valid_o` and `data_pvalid_o` are never high together, and are never high outside DELIVER.
- **`rsp_ready_o`** is combinational from registered state and FIFO occupancy only; it has no dependency on `rsp_valid_i`.

## Timing

- **Reset values:** state COLLECT, `cnt` = 0, word = 0, FIFO empty.
  - Outputs: `rsp_ready_o` = 0, `tag_full_o` = 0, `tag_empty_o` = 1, `overflow_o` = 0, `inst_rsp_valid_o` = 0, `data_pvalid_o` = 0, `inst_rsp_data_o` = 0, `data_pdata_o` = 0.
- **Tag visibility.** A tag pushed in cycle t is visible in cycle t+1, so `rsp_ready_o` can go high in t+1.
- **Latency.** The 8th nibble is accepted in cycle t; the valid for the word is high in t+1.
- **Throughput.** Minimum `NumNib+1` cycles per word (9 with defaults). The DELIVER cycle always deasserts `rsp_ready_o`.
- **Simultaneous push and pop.**
  - When full: the push is accepted and occupancy is unchanged.
  - When occupancy is 1: the FIFO stays non-empty, and the new tag becomes head in the next cycle.
- **Reset mid-operation.** Asserting `rsp_ng` is not a signal; asserting `rst_n` low at any time discards partial nibbles, the word and all tags. Outputs take their reset values immediately.

## Test plan

- Push one instruction tag, then drive nibbles 1,2,…,8 back-to-back → `inst_rsp_data_o` = 0x87654321. `inst_rsp_valid_o` is high for exactly one cycle, the cycle after the 8th accept. `tag_empty_o` returns to 1.
- Push one data tag, drive nibbles A,B,C,D,E,F,0,1, hold `data_pready_i` = 0 for 5 cycles → `data_pvalid_o` stays high with `data_pdata_o` = 0x10FEDCBA stable throughout. The response clears one cycle after `data_pready_i` = 1.
- Hold `rsp_valid_i` = 1 with the FIFO empty for 10 cycles → `rsp_ready_o` = 0 and no counter movement. Then push a tag → the first nibble is accepted in the following cycle.
- Push inst then data tags, then send two words 0x11111111 and 0x22222222 → inst port receives 0x11111111, data port receives 0x22222222, in order. `tag_full_o` = 1 after the second push.
- With `TagDepth` = 2 full, push a third tag with no pop → `overflow_o` = 1 and occupancy stays 2. Repeat the push coincident with a DELIVER pop → it is accepted and `overflow_o` is unchanged.
- Deassert `rst_n` after 3 of 8 nibbles → all outputs take reset values. Then a fresh tag plus 8 nibbles yields the correct word, with no leftover nibbles from before the reset.
